// File: rtl/multicycle_control.sv
// Multicycle LEGv8 sequencer: steps each instruction through fetch/decode/execute/memory/writeback
// over a single ready-handshaked memory port, and counts retired instructions.
module multicycle_control #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [10:0]        opcode,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               mem2reg,
  output logic               reg2loc,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               pc_src,
  output logic               retired,
  output logic [COUNT_W-1:0] retired_count,
  output logic               halt,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_R  = 4'd3,
    S_WB_R    = 4'd4,
    S_ADDR    = 4'd5,
    S_MEM_LD  = 4'd6,
    S_WB_LD   = 4'd7,
    S_MEM_ST  = 4'd8,
    S_CBZ     = 4'd9,
    S_BR      = 4'd10,
    S_ILLEGAL = 4'd15
  } state_t;

  state_t state_q;
  state_t state_d;

  logic is_rtype;
  logic is_ldur;
  logic is_stur;
  logic is_cbz;
  logic is_b;

  // Opcode classification
  always_comb begin
    is_rtype = 1'b0;
    is_ldur  = 1'b0;
    is_stur  = 1'b0;
    is_cbz   = 1'b0;
    is_b     = 1'b0;
    casez (opcode)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: is_rtype = 1'b1;
      11'b11111000010: is_ldur  = 1'b1;
      11'b11111000000: is_stur  = 1'b1;
      11'b10110100???: is_cbz   = 1'b1;
      11'b000101?????: is_b     = 1'b1;
      default:         ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if      (is_rtype)           state_d = S_EXEC_R;
        else if (is_ldur || is_stur) state_d = S_ADDR;
        else if (is_cbz)             state_d = S_CBZ;
        else if (is_b)               state_d = S_BR;
        else                         state_d = S_ILLEGAL;
      end
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R:   state_d = S_FETCH;
      S_ADDR: begin
        if      (is_ldur) state_d = S_MEM_LD;
        else if (is_stur) state_d = S_MEM_ST;
        else              state_d = S_ILLEGAL;
      end
      S_MEM_LD: if (mem_ready) state_d = S_WB_LD;
      S_WB_LD:  state_d = S_FETCH;
      S_MEM_ST: if (mem_ready) state_d = S_FETCH;
      S_CBZ:    state_d = S_FETCH;
      S_BR:     state_d = S_FETCH;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:  state_d = S_ILLEGAL;
    endcase
  end

  // Moore decode of datapath controls; memory-wait states also look at mem_ready
  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    iord      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    mem2reg   = 1'b0;
    reg2loc   = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op    = 2'b00;
    pc_src    = 1'b0;
    retired   = 1'b0;
    halt      = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        reg2loc   = is_stur | is_cbz;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        retired   = 1'b1;
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_LD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_WB_LD: begin
        reg_write = 1'b1;
        mem2reg   = 1'b1;
        retired   = 1'b1;
      end
      S_MEM_ST: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        reg2loc   = 1'b1;
        retired   = mem_ready;
      end
      S_CBZ: begin
        reg2loc  = 1'b1;
        alu_op   = 2'b01;
        pc_src   = 1'b1;
        pc_write = alu_zero;
        retired  = 1'b1;
      end
      S_BR: begin
        pc_write = 1'b1;
        pc_src   = 1'b1;
        retired  = 1'b1;
      end
      S_ILLEGAL: halt = 1'b1;
      default:   halt = 1'b1;
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clock) begin
    if (reset)        retired_count <= '0;
    else if (retired) retired_count <= retired_count + COUNT_W'(1);
  end

  assign state = state_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the LEGv8 datapath. It replaces single-cycle decode with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. A single memory port is shared between instruction fetch and load/store, with a ready handshake. The block produces every datapath mux select and write enable, counts retired instructions, and halts on unsupported opcodes.

## Interface
- COUNT_W, 32, width of retired-instruction counter

- CLOCK  in  1  sole clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high
- OPCODE  in  11  INSTRUCTION[31:21] from the instruction register; valid from DECODE onward
- ALU_ZERO  in  1  zero flag of the main ALU, same cycle
- MEM_READY  in  1  memory completed the current read/write this cycle
- PC_WRITE  out  1  load PC
- IR_WRITE  out  1  load instruction register and OLD_PC (PC of the fetched instruction)
- IORD  out  1  memory address select: 0 = PC, 1 = ALUOUT
- MEM_READ, MEM_WRITE  out  1 each  memory strobes
- REG_WRITE  out  1  register file write enable
- MEM2REG  out  1  writeback select: 1 = memory data, 0 = ALUOUT
- REG2LOC  out  1  read port 2 select: 1 = INSTRUCTION[4:0], 0 = [20:16]
- ALU_SRC_A  out  1  0 = OLD_PC/PC (per state), 1 = REG_DATA1
- ALU_SRC_B  out  2  00 REG_DATA2, 01 const 4, 10 sign-ext imm, 11 imm<<2
- ALU_OP  out  2  00 add, 01 pass B, 10 decode funct
- PC_SRC  out  1  0 = ALU result, 1 = ALUOUT (branch target)
- RETIRED  out  1  one-cycle pulse per completed instruction
- RETIRED_COUNT  out  COUNT_W  retired instruction count, wraps
- HALT  out  1  sticky, unsupported opcode seen
- STATE  out  4  current state encoding (debug)

## Operation
- State encodings: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, WB_R 4, ADDR 5, MEM_LD 6, WB_LD 7, MEM_ST 8, CBZ 9, BR 10, ILLEGAL 15.
- Outputs are decoded combinationally from state plus MEM_READY/ALU_ZERO only. Any output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH:
  - Drives MEM_READ=1, IORD=0, ALU_SRC_A=0 (PC), ALU_SRC_B=01, ALU_OP=00.
  - If MEM_READY: IR_WRITE=1, PC_WRITE=1, PC_SRC=0, next state DECODE.
  - Otherwise it stays in FETCH.
- DECODE:
  - Computes the branch target: ALU_SRC_A=0 (OLD_PC), ALU_SRC_B=11, ALU_OP=00.
  - REG2LOC=1 iff OPCODE is STUR or CBZ.
  - Next state by OPCODE:
    - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 → EXEC_R
    - LDUR 11111000010, STUR 11111000000 → ADDR
    - CBZ 10110100xxx → CBZ
    - B 000101xxxxx → BR
    - anything else → ILLEGAL
- EXEC_R: ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP=10. Next state WB_R.
- WB_R: REG_WRITE=1, MEM2REG=0, RETIRED=1. Next state FETCH.
- ADDR: ALU_SRC_A=1, ALU_SRC_B=10, ALU_OP=00. Next state MEM_LD for LDUR, MEM_ST for STUR.
- MEM_LD: MEM_READ=1, IORD=1. Waits for MEM_READY, then goes to WB_LD.
- WB_LD: REG_WRITE=1, MEM2REG=1, RETIRED=1. Next state FETCH.
- MEM_ST: MEM_WRITE=1, IORD=1, REG2LOC=1. Waits for MEM_READY; on it, RETIRED=1 and next state FETCH.
- CBZ:
  - Drives REG2LOC=1, ALU_SRC_B=00, ALU_OP=01, PC_SRC=1, PC_WRITE=ALU_ZERO, RETIRED=1.
  - Next state FETCH whether or not the branch is taken.
- BR: PC_WRITE=1, PC_SRC=1, RETIRED=1. Next state FETCH.
- ILLEGAL: HALT=1, all other outputs 0. Stays in ILLEGAL until RESET.
- RETIRED_COUNT increments by 1 on every cycle RETIRED=1. It wraps from 2^COUNT_W−1 to 0.

## Timing
- RESET sampled high at an edge:
  - Next state is IDLE; RETIRED_COUNT is 0; HALT is 0.
  - All outputs are 0 while in IDLE.
  - This holds from any state, including mid-memory-wait. An abandoned access gets no completion pulse.
- The first FETCH occurs 1 cycle after RESET deasserts, because IDLE lasts exactly 1 cycle.
- Cycles per instruction with MEM_READY=1 on the first request cycle: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3.
- Each cycle MEM_READY is low in FETCH, MEM_LD or MEM_ST adds 1 cycle.
- Strobes MEM_READ/MEM_WRITE and IORD hold constant until the MEM_READY cycle. They drop the cycle after it.
- MEM_READY is ignored in every state except FETCH, MEM_LD and MEM_ST.
- Only one strobe is ever high at a time. MEM_READ and MEM_WRITE are never both 1.
- PC_WRITE never fires on an un-ready FETCH cycle.

## Test plan
- Reset then ADD opcode, MEM_READY tied 1 → STATE 0,1,2,3,4,1. REG_WRITE=1 only in state 4. RETIRED_COUNT=1 after 5 edges.
- LDUR with MEM_READY low 2 cycles in MEM_LD → MEM_READ/IORD=1 held 3 cycles. WB_LD has MEM2REG=1. Total 7 cycles.
- CBZ with ALU_ZERO=1, then repeat with ALU_ZERO=0 → PC_WRITE=1 in CBZ for the first, 0 for the second. Both return to FETCH and both retire.
- OPCODE 00000000000 → STATE 15, HALT=1 held 20 cycles with no strobes. RESET → HALT=0, STATE=0.
- RESET asserted in MEM_ST while MEM_READY=0 → next cycle MEM_WRITE=0 and STATE=0. RETIRED_COUNT=0.
- COUNT_W=4, 17 B instructions → RETIRED_COUNT reads 1 after wrap. Every MEM_READY cycle in FETCH shows IR_WRITE=PC_WRITE=1.
